vcc_tokenizer: RTL

Streaming lexer that turns C source bytes into the token stream consumed by the vcc parser. It accepts one source byte per cycle on a valid/ready input, emits one classified token per handshake on a valid/ready output, and appends a single EOF token after the last byte. Token kinds and the reserved-word set match exactly what the parser matches against.

---
 rtl/vcc_tokenizer.sv | 338 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vcc_tokenizer.sv
// Streaming C lexer: one source byte per cycle in, one classified token per handshake out,
// terminated by a single EOF token carrying the total byte count.
module vcc_tokenizer #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned POS_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   out_kind,
  output logic [8*MAX_LEN-1:0]         out_str,
  output logic [$clog2(MAX_LEN+1)-1:0] out_len,
  output logic [31:0]                  out_num,
  output logic [POS_W-1:0]             out_pos,
  output logic                         err,
  output logic [POS_W-1:0]             err_pos
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 1);
  localparam int unsigned StrW = 8 * MAX_LEN;
  localparam int unsigned ExtW = (StrW > 48) ? StrW : 48;

  localparam logic [1:0] KindRsv   = 2'd0;
  localparam logic [1:0] KindIdent = 2'd1;
  localparam logic [1:0] KindNum   = 2'd2;
  localparam logic [1:0] KindEof   = 2'd3;

  typedef enum logic [2:0] {
    StScan, StIdent, StNum, StPunct2, StFlush, StEoft, StDone, StErr
  } state_e;

  typedef enum logic [1:0] {PendIdent, PendNum, PendPunct} pend_e;

  typedef enum logic [2:0] {SelIdent, SelNum, SelChar, SelPair, SelEof} sel_e;

  function automatic logic is_alpha(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a) || c == 8'h5f;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  function automatic logic is_space(input logic [7:0] c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0a || c == 8'h0d;
  endfunction

  function automatic logic is_punct1(input logic [7:0] c);
    return c inside {8'h2b, 8'h2d, 8'h2a, 8'h2f, 8'h28, 8'h29, 8'h3b,
                     8'h7b, 8'h7d, 8'h2c, 8'h26, 8'h5b, 8'h5d};
  endfunction

  function automatic logic is_punct2(input logic [7:0] c);
    return c inside {8'h3d, 8'h21, 8'h3c, 8'h3e};
  endfunction

  // Text is zero-padded past its length, so a full-width compare is exact.
  function automatic logic is_kw(input logic [StrW-1:0] s);
    logic [ExtW-1:0] x;
    x = ExtW'(s);
    return x == ExtW'(48'h0000_0074_6e69)    // int
        || x == ExtW'(48'h6e72_7574_6572)    // return
        || x == ExtW'(48'h0000_0000_6669)    // if
        || x == ExtW'(48'h0000_6573_6c65)    // else
        || x == ExtW'(48'h0000_0072_6f66)    // for
        || x == ExtW'(48'h0065_6c69_6877)    // while
        || x == ExtW'(48'h666f_657a_6973);   // sizeof
  endfunction

  state_e            state_q, state_d;
  pend_e             pend_q, pend_d;
  logic [POS_W-1:0]  pos_q, pos_d, tok_pos_q, tok_pos_d, err_pos_q, err_pos_d;
  logic [StrW-1:0]   text_q, text_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [31:0]       acc_q, acc_d;
  logic              err_q, err_d;
  logic              live_q;

  logic              out_valid_q;
  logic [1:0]        out_kind_q;
  logic [StrW-1:0]   out_str_q;
  logic [LenW-1:0]   out_len_q;
  logic [31:0]       out_num_q;
  logic [POS_W-1:0]  out_pos_q;

  logic              step, emit;
  sel_e              sel;
  logic [7:0]        e_char;
  logic [POS_W-1:0]  e_cpos;
  logic [1:0]        tok_kind;
  logic [StrW-1:0]   tok_str;
  logic [LenW-1:0]   tok_len;
  logic [31:0]       tok_num;
  logic [POS_W-1:0]  tok_pos;

  // The whole lexer freezes while the output register holds a token.
  assign step = live_q && !rst && !out_valid_q;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pos_d     = pos_q;
    tok_pos_d = tok_pos_q;
    text_d    = text_q;
    len_d     = len_q;
    acc_d     = acc_q;
    err_d     = err_q;
    err_pos_d = err_pos_q;
    in_ready  = 1'b0;
    emit      = 1'b0;
    sel       = SelEof;
    e_char    = 8'h00;
    e_cpos    = tok_pos_q;

    unique case (state_q)
      StScan: begin
        in_ready = step;
        if (step && in_valid) begin
          pos_d       = pos_q + POS_W'(1);
          tok_pos_d   = pos_q;
          text_d      = '0;
          text_d[7:0] = in_data;
          len_d       = LenW'(1);
          if (is_space(in_data)) begin
            state_d = in_last ? StEoft : StScan;
          end else if (is_alpha(in_data)) begin
            pend_d  = PendIdent;
            state_d = in_last ? StFlush : StIdent;
          end else if (is_digit(in_data)) begin
            acc_d   = 32'(in_data - 8'h30);
            pend_d  = PendNum;
            state_d = in_last ? StFlush : StNum;
          end else if (is_punct1(in_data)) begin
            emit    = 1'b1;
            sel     = SelChar;
            e_char  = in_data;
            e_cpos  = pos_q;
            state_d = in_last ? StEoft : StScan;
          end else if (is_punct2(in_data)) begin
            pend_d  = PendPunct;
            state_d = in_last ? StFlush : StPunct2;
          end else begin
            err_d     = 1'b1;
            err_pos_d = pos_q;
            state_d   = StErr;
          end
        end
      end

      StIdent: begin
        in_ready = step && (is_alpha(in_data) || is_digit(in_data));
        if (step && in_valid) begin
          if (is_alpha(in_data) || is_digit(in_data)) begin
            if (len_q == LenW'(MAX_LEN)) begin
              err_d     = 1'b1;
              err_pos_d = pos_q;
              state_d   = StErr;
            end else begin
              for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (len_q == LenW'(i)) text_d[8*i +: 8] = in_data;
              end
              len_d   = len_q + LenW'(1);
              pos_d   = pos_q + POS_W'(1);
              state_d = in_last ? StFlush : StIdent;
            end
          end else begin
            emit    = 1'b1;
            sel     = SelIdent;
            state_d = StScan;
          end
        end
      end

      StNum: begin
        in_ready = step && is_digit(in_data);
        if (step && in_valid) begin
          if (is_digit(in_data)) begin
            acc_d   = acc_q * 32'd10 + 32'(in_data - 8'h30);
            pos_d   = pos_q + POS_W'(1);
            state_d = in_last ? StFlush : StNum;
          end else begin
            emit    = 1'b1;
            sel     = SelNum;
            state_d = StScan;
          end
        end
      end

      StPunct2: begin
        in_ready = step && (in_data == 8'h3d);
        if (step && in_valid) begin
          if (in_data == 8'h3d) begin
            emit    = 1'b1;
            sel     = SelPair;
            pos_d   = pos_q + POS_W'(1);
            state_d = in_last ? StEoft : StScan;
          end else if (text_q[7:0] == 8'h21) begin
            err_d     = 1'b1;
            err_pos_d = tok_pos_q;
            state_d   = StErr;
          end else begin
            emit    = 1'b1;
            sel     = SelChar;
            e_char  = text_q[7:0];
            state_d = StScan;
          end
        end
      end

      StFlush: begin
        if (step) begin
          state_d = StEoft;
          case (pend_q)
            PendIdent: begin
              emit = 1'b1;
              sel  = SelIdent;
            end
            PendNum: begin
              emit = 1'b1;
              sel  = SelNum;
            end
            default: begin
              if (text_q[7:0] == 8'h21) begin
                err_d     = 1'b1;
                err_pos_d = tok_pos_q;
                state_d   = StErr;
              end else begin
                emit   = 1'b1;
                sel    = SelChar;
                e_char = text_q[7:0];
              end
            end
          endcase
        end
      end

      StEoft: begin
        if (step) begin
          emit    = 1'b1;
          sel     = SelEof;
          state_d = StDone;
        end
      end

      StDone, StErr: ;
    endcase
  end

  always_comb begin
    tok_kind = KindRsv;
    tok_str  = '0;
    tok_len  = '0;
    tok_num  = '0;
    tok_pos  = tok_pos_q;
    case (sel)
      SelIdent: begin
        tok_kind = is_kw(text_q) ? KindRsv : KindIdent;
        tok_str  = text_q;
        tok_len  = len_q;
      end
      SelNum: begin
        tok_kind = KindNum;
        tok_num  = acc_q;
      end
      SelChar: begin
        tok_str[7:0] = e_char;
        tok_len      = LenW'(1);
        tok_pos      = e_cpos;
      end
      SelPair: begin
        tok_str[7:0]  = text_q[7:0];
        tok_str[15:8] = 8'h3d;
        tok_len       = LenW'(2);
      end
      default: begin
        tok_kind = KindEof;
        tok_pos  = pos_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StScan;
      pend_q      <= PendIdent;
      pos_q       <= '0;
      tok_pos_q   <= '0;
      text_q      <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      err_pos_q   <= '0;
      live_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_kind_q  <= '0;
      out_str_q   <= '0;
      out_len_q   <= '0;
      out_num_q   <= '0;
      out_pos_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pos_q     <= pos_d;
      tok_pos_q <= tok_pos_d;
      text_q    <= text_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      err_pos_q <= err_pos_d;
      live_q    <= 1'b1;
      if (emit) begin
        out_valid_q <= 1'b1;
        out_kind_q  <= tok_kind;
        out_str_q   <= tok_str;
        out_len_q   <= tok_len;
        out_num_q   <= tok_num;
        out_pos_q   <= tok_pos;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_kind  = out_kind_q;
  assign out_str   = out_str_q;
  assign out_len   = out_len_q;
  assign out_num   = out_num_q;
  assign out_pos   = out_pos_q;
  assign err       = err_q;
  assign err_pos   = err_pos_q;

endmodule
